lock_keypad_driver: RTL and testbench

Keypad-side front end for the digital lock. It debounces a raw keypad strobe, latches the entered 4-bit code, and drives it to the lock's `input_code` input. It interprets the lock's `unlock`/`alarm` response as a timed door-open window or a counted failure, and escalates to a timed lockout after repeated failures. It sits between the physical keypad and the combinational lock comparator.

---
 rtl/lock_keypad_driver.sv | 156 +++++++++++++++
 tb/tb_lock_keypad_driver.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/lock_keypad_driver.sv
// lock_keypad_driver
//
// Keypad-side front end for the digital lock. The raw key strobe is
// synchronized and debounced. Each accepted press latches the 4-bit key code
// onto input_code and pulses code_valid for one cycle. During that cycle the
// lock's combinational unlock/alarm response is sampled. A success opens a
// timed door window. A failure is counted, and repeated failures escalate to
// a timed lockout.
//
// Parameters:
//   DEBOUNCE_CYCLES  synchronized-high cycles needed to accept a press (1..255)
//   MAX_ATTEMPTS     consecutive failures that trigger lockout (1..7)
//   OPEN_CYCLES      door_open duration in cycles (1..65535)
//   LOCKOUT_CYCLES   lockout duration in cycles (1..65535)
//
// Ports:
//   clk          single clock, rising edge
//   reset        asynchronous, active-high reset
//   key_press    raw, asynchronous, bouncy key strobe
//   key_data     code of the pressed key, stable while key_press is high
//   unlock       lock response (combinational from input_code)
//   alarm        lock response (combinational from input_code)
//   input_code   registered code presented to the lock
//   code_valid   one-cycle pulse; the lock response is sampled in this cycle
//   door_open    high during the open window
//   lockout      high during the lockout window
//   fail_count   consecutive failures since last success or lockout expiry

module lock_keypad_driver #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int MAX_ATTEMPTS    = 3,
  parameter int OPEN_CYCLES     = 8,
  parameter int LOCKOUT_CYCLES  = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       key_press,
  input  logic [3:0] key_data,
  input  logic       unlock,
  input  logic       alarm,
  output logic [3:0] input_code,
  output logic       code_valid,
  output logic       door_open,
  output logic       lockout,
  output logic [2:0] fail_count
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_CHECK   = 2'd1;
  localparam logic [1:0] S_OPEN    = 2'd2;
  localparam logic [1:0] S_LOCKOUT = 2'd3;

  localparam logic [7:0]  DEB_MAX   = 8'(DEBOUNCE_CYCLES);
  localparam logic [2:0]  MAX_FAIL  = 3'(MAX_ATTEMPTS);
  // Timers load with count-1 so the output stays high for exactly N cycles.
  localparam logic [15:0] OPEN_LAST = 16'(OPEN_CYCLES - 1);
  localparam logic [15:0] LOCK_LAST = 16'(LOCKOUT_CYCLES - 1);

  logic        sync1_reg;
  logic        kp_s;
  logic [7:0]  deb_cnt_reg;
  logic        accept;
  logic [1:0]  state_reg;
  logic [15:0] timer_reg;
  logic [2:0]  fail_next;

  // Two-flop synchronizer on the raw strobe.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_reg <= 1'b0;
      kp_s      <= 1'b0;
    end else begin
      sync1_reg <= key_press;
      kp_s      <= sync1_reg;
    end
  end

  // The debounce counter saturates at DEB_MAX. Because it saturates, a long
  // hold produces only one acceptance, and the key must be released to re-arm.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      deb_cnt_reg <= 8'd0;
    end else if (!kp_s) begin
      deb_cnt_reg <= 8'd0;
    end else if (deb_cnt_reg != DEB_MAX) begin
      deb_cnt_reg <= deb_cnt_reg + 8'd1;
    end
  end

  // Acceptance is the edge on which the counter reaches DEB_MAX.
  assign accept    = kp_s && (deb_cnt_reg == DEB_MAX - 8'd1);
  assign fail_next = fail_count + 3'd1;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg  <= S_IDLE;
      input_code <= 4'd0;
      code_valid <= 1'b0;
      door_open  <= 1'b0;
      lockout    <= 1'b0;
      fail_count <= 3'd0;
      timer_reg  <= 16'd0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          // Acceptances outside IDLE are dropped, not queued.
          if (accept) begin
            input_code <= key_data;
            code_valid <= 1'b1;
            state_reg  <= S_CHECK;
          end
        end
        S_CHECK: begin
          code_valid <= 1'b0;
          // Alarm wins over unlock when the lock reports both.
          if (alarm) begin
            fail_count <= fail_next;
            if (fail_next == MAX_FAIL) begin
              lockout   <= 1'b1;
              timer_reg <= LOCK_LAST;
              state_reg <= S_LOCKOUT;
            end else begin
              state_reg <= S_IDLE;
            end
          end else if (unlock) begin
            fail_count <= 3'd0;
            door_open  <= 1'b1;
            timer_reg  <= OPEN_LAST;
            state_reg  <= S_OPEN;
          end else begin
            state_reg <= S_IDLE;
          end
        end
        S_OPEN: begin
          if (timer_reg == 16'd0) begin
            door_open <= 1'b0;
            state_reg <= S_IDLE;
          end else begin
            timer_reg <= timer_reg - 16'd1;
          end
        end
        S_LOCKOUT: begin
          if (timer_reg == 16'd0) begin
            lockout    <= 1'b0;
            fail_count <= 3'd0;
            state_reg  <= S_IDLE;
          end else begin
            timer_reg <= timer_reg - 16'd1;
          end
        end
        default: state_reg <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lock_keypad_driver.sv
// tb_lock_keypad_driver
//
// Directed bench for lock_keypad_driver with default parameters. A small lock
// model drives unlock/alarm from input_code: 1010 unlocks, and any other code
// raises alarm. force_both makes the lock assert both responses. A negedge
// monitor counts code_valid pulses and measures door_open/lockout widths.

module tb_lock_keypad_driver;

  localparam logic [3:0] SECRET = 4'b1010;

  logic       clk = 1'b0;
  logic       reset;
  logic       key_press;
  logic [3:0] key_data;
  logic       unlock;
  logic       alarm;
  logic [3:0] input_code;
  logic       code_valid;
  logic       door_open;
  logic       lockout;
  logic [2:0] fail_count;
  logic       force_both;

  int tests_run    = 0;
  int tests_failed = 0;

  int cv_count   = 0;
  int door_run   = 0;
  int door_last  = 0;
  int door_rises = 0;
  int lock_run   = 0;
  int lock_last  = 0;

  lock_keypad_driver dut (
    .clk        (clk),
    .reset      (reset),
    .key_press  (key_press),
    .key_data   (key_data),
    .unlock     (unlock),
    .alarm      (alarm),
    .input_code (input_code),
    .code_valid (code_valid),
    .door_open  (door_open),
    .lockout    (lockout),
    .fail_count (fail_count)
  );

  always #5 clk = ~clk;

  assign unlock = force_both || (input_code == SECRET);
  assign alarm  = force_both || (input_code != SECRET);

  always @(negedge clk) begin
    if (code_valid) cv_count++;
    if (door_open) begin
      if (door_run == 0) door_rises++;
      door_run++;
    end else if (door_run != 0) begin
      door_last = door_run;
      door_run  = 0;
    end
    if (lockout) begin
      lock_run++;
    end else if (lock_run != 0) begin
      lock_last = lock_run;
      lock_run  = 0;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end else begin
      $display("[TB] ok %s = %0d", tag, got);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      #1;
    end
  endtask

  // Start a press and return how many negedges it took for code_valid to be
  // seen. The key stays held; the caller releases it.
  task automatic press_start(input logic [3:0] code, output int lat);
    @(negedge clk);
    key_data  = code;
    key_press = 1'b1;
    lat = 0;
    while (!code_valid && lat < 30) begin
      @(negedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic release_key(input int extra);
    tick(extra);
    key_press = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while ((door_open || lockout) && n < 200) begin
      tick(1);
      n++;
    end
    check(tag, 32'(n < 200), 32'd1);
    tick(3);
  endtask

  task automatic pulse(input int len);
    @(negedge clk);
    key_data  = SECRET;
    key_press = 1'b1;
    tick(len);
    key_press = 1'b0;
    tick(4);
  endtask

  initial begin
    int lat;
    int base;
    int rises;
    reset      = 1'b1;
    key_press  = 1'b0;
    key_data   = 4'd0;
    force_both = 1'b0;
    tick(3);
    check("rst_input_code", 32'(input_code), 32'd0);
    check("rst_code_valid", 32'(code_valid), 32'd0);
    check("rst_door_open",  32'(door_open),  32'd0);
    check("rst_lockout",    32'(lockout),    32'd0);
    check("rst_fail_count", 32'(fail_count), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    tick(2);

    // Correct code: code_valid is seen at the 6th negedge after the press starts.
    press_start(SECRET, lat);
    check("ok_latency", 32'(lat), 32'd6);
    check("ok_input_code", 32'(input_code), 32'(SECRET));
    tick(1);
    check("ok_cv_one_cycle", 32'(code_valid), 32'd0);
    check("ok_door_rise", 32'(door_open), 32'd1);
    release_key(3);
    wait_idle("ok_idle");
    check("ok_door_len", 32'(door_last), 32'd8);
    check("ok_fail_count", 32'(fail_count), 32'd0);
    check("ok_cv_total", 32'(cv_count), 32'd1);

    // Reset asserted mid-OPEN clears every output before the next edge.
    press_start(SECRET, lat);
    release_key(1);
    tick(3);
    check("mid_door_open", 32'(door_open), 32'd1);
    #2 reset = 1'b1;
    #1;
    check("mid_rst_door", 32'(door_open), 32'd0);
    check("mid_rst_code", 32'(input_code), 32'd0);
    check("mid_rst_cv", 32'(code_valid), 32'd0);
    check("mid_rst_lock", 32'(lockout), 32'd0);
    check("mid_rst_fail", 32'(fail_count), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    tick(2);
    press_start(SECRET, lat);
    check("post_rst_latency", 32'(lat), 32'd6);
    release_key(2);
    wait_idle("post_rst_idle");
    check("post_rst_door_len", 32'(door_last), 32'd8);

    // Bounce rejection, then one press per hold.
    base  = cv_count;
    rises = door_rises;
    pulse(1);
    pulse(2);
    pulse(3);
    check("bounce_no_cv", 32'(cv_count - base), 32'd0);
    pulse(10);
    wait_idle("bounce_idle");
    check("bounce_one_cv", 32'(cv_count - base), 32'd1);
    pulse(40);
    wait_idle("hold_idle");
    check("hold_one_cv", 32'(cv_count - base), 32'd2);
    check("hold_door_rises", 32'(door_rises - rises), 32'd2);

    // Failure escalation to lockout.
    press_start(4'b1100, lat);
    release_key(2);
    tick(3);
    check("esc_fail1", 32'(fail_count), 32'd1);
    press_start(4'b0110, lat);
    release_key(2);
    tick(3);
    check("esc_fail2", 32'(fail_count), 32'd2);
    press_start(4'b1100, lat);
    check("esc_code3", 32'(input_code), 32'b1100);
    tick(1);
    check("esc_lockout_rise", 32'(lockout), 32'd1);
    check("esc_fail3", 32'(fail_count), 32'd3);
    release_key(1);
    base = cv_count;
    @(negedge clk);
    key_data  = 4'b0110;
    key_press = 1'b1;
    tick(8);
    key_press = 1'b0;
    tick(1);
    check("lock_press_no_cv", 32'(cv_count - base), 32'd0);
    check("lock_press_code", 32'(input_code), 32'b1100);
    wait_idle("lock_idle");
    check("lock_len", 32'(lock_last), 32'd16);
    check("lock_fail_clear", 32'(fail_count), 32'd0);
    check("lock_no_late_cv", 32'(cv_count - base), 32'd0);

    // Recovery: two failures, then the correct code clears the count.
    press_start(4'b0001, lat);
    release_key(2);
    tick(3);
    press_start(4'b0010, lat);
    release_key(2);
    tick(3);
    check("rec_fail2", 32'(fail_count), 32'd2);
    press_start(SECRET, lat);
    tick(1);
    check("rec_fail_clear", 32'(fail_count), 32'd0);
    check("rec_door", 32'(door_open), 32'd1);
    release_key(1);
    wait_idle("rec_idle");

    // Priority: unlock and alarm together count as a failure.
    force_both = 1'b1;
    rises = door_rises;
    press_start(SECRET, lat);
    check("prio_cv_seen", 32'(lat < 30), 32'd1);
    release_key(2);
    tick(10);
    check("prio_fail1", 32'(fail_count), 32'd1);
    check("prio_no_door", 32'(door_rises - rises), 32'd0);
    force_both = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
